// File: rtl/data_memory_pipe.sv
// -----------------------------------------------------------------------------
// data_memory_pipe
// Single-port synchronous data memory between the CPU load/store stage and the
// storage array. It has a req/ready handshake, byte-enable writes and a
// read-response pipeline of RD_LAT register stages. Accesses at or above DEPTH
// are flagged on err. After reset, or when clr is seen in IDLE, a small state
// machine zero-fills the whole array, one word per cycle.
//
// Ports:
//   clk    - system clock, rising edge
//   rst_n  - asynchronous active-low reset
//   req    - access request, accepted when ready=1
//   we     - 1 = write, 0 = read (sampled with req)
//   addr   - word address
//   wdata  - write data
//   be     - byte enables for writes, bit i covers wdata[8i+7:8i]
//   clr    - request a full-array zero clear (honoured in IDLE only)
//   ready  - block accepts a request this cycle
//   rvalid - one-cycle pulse, rdata carries a read response
//   rdata  - read data, held until the next rvalid
//   err    - one-cycle pulse for an out-of-range access
//   busy   - clear in progress
// -----------------------------------------------------------------------------
module data_memory_pipe #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 11,
    parameter int DEPTH  = 2048,
    parameter int RD_LAT = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req,
    input  logic                we,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] be,
    input  logic                clr,
    output logic                ready,
    output logic                rvalid,
    output logic [DATA_W-1:0]   rdata,
    output logic                err,
    output logic                busy
);

    localparam int BE_W  = DATA_W / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_IDLE  = 1'b1;

    logic [0:0]        state_r;
    logic [0:0]        state_nxt_s;
    logic [IDX_W-1:0]  clr_ptr_r;
    logic              ready_r;
    logic              busy_r;
    logic              err_r;

    logic [DATA_W-1:0] mem_r [DEPTH];

    logic              acc_s;
    logic              wr_acc_s;
    logic              rd_acc_s;
    logic              in_range_s;
    logic              wr_oob_s;
    logic [IDX_W-1:0]  idx_s;
    logic [DATA_W-1:0] rd_word_s;

    // Read pipeline: stage k is loaded from in_*_s[k]; the last stage drives the outputs.
    logic              pv_r   [RD_LAT];
    logic [DATA_W-1:0] pd_r   [RD_LAT];
    logic              in_v_s [RD_LAT];
    logic [DATA_W-1:0] in_d_s [RD_LAT];
    logic              in_e_s [RD_LAT];

    // ready_r is high exactly in IDLE, so it doubles as the accept qualifier.
    assign acc_s      = req & ready_r;
    assign wr_acc_s   = acc_s & we;
    assign rd_acc_s   = acc_s & ~we;
    assign in_range_s = (32'(addr) < 32'(DEPTH));
    assign idx_s      = addr[IDX_W-1:0];
    // A write with no byte enabled is a no-op and is not reported even out of range.
    assign wr_oob_s   = wr_acc_s & ~in_range_s & (|be);

    assign ready  = ready_r;
    assign busy   = busy_r;
    assign err    = err_r;
    assign rvalid = pv_r[RD_LAT-1];
    assign rdata  = pd_r[RD_LAT-1];

    // Next-state logic for the clear/idle controller.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_CLEAR: begin
                if (clr_ptr_r == IDX_W'(DEPTH - 1)) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_CLEAR;
                end
            end
            ST_IDLE: begin
                if (clr) begin
                    state_nxt_s = ST_CLEAR;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            default: state_nxt_s = ST_CLEAR;
        endcase
    end

    // Controller state, clear pointer and the registered ready/busy decodes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_CLEAR;
            clr_ptr_r <= '0;
            ready_r   <= 1'b0;
            busy_r    <= 1'b1;
        end else begin
            state_r <= state_nxt_s;
            ready_r <= (state_nxt_s == ST_IDLE);
            busy_r  <= (state_nxt_s == ST_CLEAR);
            if (state_r == ST_CLEAR) begin
                clr_ptr_r <= clr_ptr_r + IDX_W'(1);
            end else if (state_nxt_s == ST_CLEAR) begin
                clr_ptr_r <= '0;
            end else begin
                clr_ptr_r <= clr_ptr_r;
            end
        end
    end

    // Storage array: zero-fill while clearing, otherwise byte-enabled writes.
    always_ff @(posedge clk) begin
        if (state_r == ST_CLEAR) begin
            mem_r[clr_ptr_r] <= '0;
        end else if (wr_acc_s && in_range_s) begin
            for (int i = 0; i < BE_W; i++) begin
                if (be[i]) begin
                    mem_r[idx_s][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    // Word presented to the read pipeline; out-of-range reads return zero.
    always_comb begin
        if (in_range_s) begin
            rd_word_s = mem_r[idx_s];
        end else begin
            rd_word_s = '0;
        end
    end

    // Inputs of each read-pipeline stage.
    always_comb begin
        for (int k = 0; k < RD_LAT; k++) begin
            in_v_s[k] = 1'b0;
            in_d_s[k] = '0;
            in_e_s[k] = 1'b0;
        end
        in_v_s[0] = rd_acc_s;
        in_d_s[0] = rd_word_s;
        in_e_s[0] = rd_acc_s & ~in_range_s;
        for (int k = 1; k < RD_LAT; k++) begin
            in_v_s[k] = pv_r[k-1];
            in_d_s[k] = pd_r[k-1];
            in_e_s[k] = pv_r[k-1] & in_e_s[k-1];
        end
    end

    // Read pipeline registers; data only moves with a valid so rdata holds between responses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < RD_LAT; k++) begin
                pv_r[k] <= 1'b0;
                pd_r[k] <= '0;
            end
        end else begin
            for (int k = 0; k < RD_LAT; k++) begin
                pv_r[k] <= in_v_s[k];
                if (in_v_s[k]) begin
                    pd_r[k] <= in_d_s[k];
                end else begin
                    pd_r[k] <= pd_r[k];
                end
            end
        end
    end

    // Error flag tracking: a parallel 1-bit shift of the out-of-range marker.
    logic pe_r [RD_LAT];

    // Out-of-range marker carried alongside each in-flight read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < RD_LAT; k++) begin
                pe_r[k] <= 1'b0;
            end
        end else begin
            pe_r[0] <= rd_acc_s & ~in_range_s;
            for (int k = 1; k < RD_LAT; k++) begin
                pe_r[k] <= pv_r[k-1] & pe_r[k-1];
            end
        end
    end

    // err pulses after an out-of-range write accept, or together with a bad read's rvalid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_r <= 1'b0;
        end else begin
            if (RD_LAT == 1) begin
                err_r <= wr_oob_s | (rd_acc_s & ~in_range_s);
            end else begin
                err_r <= wr_oob_s | (pv_r[(RD_LAT > 1) ? RD_LAT-2 : 0] & pe_r[(RD_LAT > 1) ? RD_LAT-2 : 0]);
            end
        end
    end

endmodule
